pix_frame_scanout: RTL

//  Downstream consumer of the display circuit's pix bitmap (WIDTH*HEIGHT bits per evaluated frame).

---
 rtl/display_pkg.sv | 15 +
 rtl/pix_frame_scanout_if.sv | 26 ++
 rtl/pix_word_select.sv | 22 ++
 rtl/pix_frame_scanout.sv | 118 +++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display geometry defaults, reader state and sizing helper
package display_pkg;
   localparam int WIDTH  = 120;
   localparam int HEIGHT = 52;
   localparam int WORD_W = 8;
   localparam int WPR    = WIDTH / WORD_W;
   localparam int BEATS  = WPR * HEIGHT;

   typedef enum logic {IDLE, STREAM} rd_state_t;

   // Counter width that stays legal when a dimension collapses to 1.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pix_frame_scanout_if.sv
// rtl/pix_frame_scanout_if.sv - frame capture handshake and beat stream bundle
interface pix_frame_scanout_if #(
   parameter int WIDTH  = display_pkg::WIDTH,
   parameter int HEIGHT = display_pkg::HEIGHT,
   parameter int WORD_W = display_pkg::WORD_W
) ();
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH*HEIGHT-1:0]  in_pix;
   logic                     out_valid;
   logic                     out_ready;
   logic [WORD_W-1:0]        out_data;
   logic                     out_sof;
   logic                     out_eol;
   logic                     out_eof;

   modport slave (
      input  in_valid, in_pix, out_ready,
      output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
   );

   modport master (
      output in_valid, in_pix, out_ready,
      input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
   );
endinterface

// File: rtl/pix_word_select.sv
// rtl/pix_word_select.sv - picks the WORD_W-pixel word at (row,col) out of a frame bank
module pix_word_select
   import display_pkg::*;
#(
   parameter int WIDTH  = display_pkg::WIDTH,
   parameter int HEIGHT = display_pkg::HEIGHT,
   parameter int WORD_W = display_pkg::WORD_W,
   parameter int ROW_W  = 6,
   parameter int COL_W  = 4
) (
   input  logic [WIDTH*HEIGHT-1:0] i_bank,
   input  logic [ROW_W-1:0]        i_row,
   input  logic [COL_W-1:0]        i_col,
   output logic [WORD_W-1:0]       o_word
);
   localparam int IDX_W = clog2_min1(WIDTH * HEIGHT);

   logic [IDX_W-1:0] w_base;

   assign w_base = IDX_W'(i_row) * IDX_W'(WIDTH) + IDX_W'(i_col) * IDX_W'(WORD_W);
   assign o_word = i_bank[w_base +: WORD_W];
endmodule

// File: rtl/pix_frame_scanout.sv
// rtl/pix_frame_scanout.sv - ping-pong frame capture with raster-order beat streaming
module pix_frame_scanout
   import display_pkg::*;
#(
   parameter int WIDTH  = display_pkg::WIDTH,
   parameter int HEIGHT = display_pkg::HEIGHT,
   parameter int WORD_W = display_pkg::WORD_W,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   pix_frame_scanout_if.slave bus,
   output logic [CNT_W-1:0] frame_cnt
);
   localparam int NPIX  = WIDTH * HEIGHT;
   localparam int L_WPR = WIDTH / WORD_W;
   localparam int COL_W = clog2_min1(L_WPR);
   localparam int ROW_W = clog2_min1(HEIGHT);

   logic [NPIX-1:0]   r_bank [2];
   logic [1:0]        r_full;
   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   rd_state_t         r_state;
   logic              r_out_valid;
   logic [CNT_W-1:0]  r_frame_cnt;

   logic              w_capture;
   logic              w_beat;
   logic              w_last_col;
   logic              w_eof;
   logic [WORD_W-1:0] w_word;

   assign bus.in_ready = !rst && !r_full[r_wr_bank];
   assign w_capture    = bus.in_valid && bus.in_ready;
   assign w_beat       = r_out_valid && bus.out_ready;
   assign w_last_col   = (r_col == COL_W'(L_WPR - 1));
   assign w_eof        = w_last_col && (r_row == ROW_W'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_bank[r_wr_bank] <= bus.in_pix;
      end
   end

   // A capture into the bank the idle reader points at starts streaming on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full      <= 2'b00;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_col       <= '0;
         r_row       <= '0;
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (w_capture) begin
            r_full[r_wr_bank] <= 1'b1;
            r_wr_bank         <= ~r_wr_bank;
         end
         case (r_state)
            IDLE: begin
               if (r_full[r_rd_bank] || (w_capture && (r_wr_bank == r_rd_bank))) begin
                  r_state     <= STREAM;
                  r_out_valid <= 1'b1;
               end
            end
            STREAM: begin
               if (w_beat) begin
                  if (w_eof) begin
                     r_col             <= '0;
                     r_row             <= '0;
                     r_full[r_rd_bank] <= 1'b0;
                     r_rd_bank         <= ~r_rd_bank;
                     r_frame_cnt       <= r_frame_cnt + 1'b1;
                     if (!r_full[~r_rd_bank]) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                     end
                  end else if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   pix_word_select #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .WORD_W (WORD_W),
      .ROW_W  (ROW_W),
      .COL_W  (COL_W)
   ) u_word_select (
      .i_bank (r_bank[r_rd_bank]),
      .i_row  (r_row),
      .i_col  (r_col),
      .o_word (w_word)
   );

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = w_word;
   assign bus.out_sof   = r_out_valid && (r_row == '0) && (r_col == '0);
   assign bus.out_eol   = r_out_valid && w_last_col;
   assign bus.out_eof   = r_out_valid && w_eof;
   assign frame_cnt     = r_frame_cnt;
endmodule
